// File: rtl/lcd_pkg.sv
// HD44780 command bytes, microsecond delays and sequencer state codes shared by the LCD frame driver.
package lcd_pkg;

    localparam logic [7:0] FUNC_4BIT_2L = 8'h28;
    localparam logic [7:0] DISP_ON      = 8'h0C;
    localparam logic [7:0] CLEAR        = 8'h01;
    localparam logic [7:0] RET_HOME     = 8'h02;
    localparam logic [7:0] ENTRY_INC    = 8'h06;
    localparam logic [7:0] DDRAM_L1     = 8'h80;
    localparam logic [7:0] DDRAM_L2     = 8'hC0;

    localparam int PWRUP_US  = 15000;
    localparam int INIT3A_US = 4100;
    localparam int INIT_US   = 100;
    localparam int NIB_HI_US = 1;
    localparam int CMD_US    = 40;
    localparam int CLR_US    = 1640;

    localparam logic [3:0] ST_PWRUP  = 4'd0;
    localparam logic [3:0] ST_INIT3A = 4'd1;
    localparam logic [3:0] ST_INIT3B = 4'd2;
    localparam logic [3:0] ST_INIT3C = 4'd3;
    localparam logic [3:0] ST_INIT2  = 4'd4;
    localparam logic [3:0] ST_CFG    = 4'd5;
    localparam logic [3:0] ST_ADDR1  = 4'd6;
    localparam logic [3:0] ST_LINE1  = 4'd7;
    localparam logic [3:0] ST_ADDR2  = 4'd8;
    localparam logic [3:0] ST_LINE2  = 4'd9;
    localparam logic [3:0] ST_GAP    = 4'd10;

    function automatic logic [7:0] cfg_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return FUNC_4BIT_2L;
            2'd1:    return DISP_ON;
            2'd2:    return CLEAR;
            default: return ENTRY_INC;
        endcase
    endfunction

endpackage

// File: rtl/lcd_frame_driver_nibble_tx.sv
// One 4-bit LCD bus transfer: setup, E pulse, hold, then a caller-chosen post-delay before done.
// Latency: 3*E_PULSE_CLKS + post_clks + 1 cycles from start; start is ignored while busy.
module lcd_nibble_tx #(
    parameter int E_PULSE_CLKS = 25,
    parameter int DW           = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          rs,
    input  logic [3:0]    nib,
    input  logic [DW-1:0] post_clks,
    output logic          busy,
    output logic          done,
    output logic          lcd_rs,
    output logic          lcd_e,
    output logic [3:0]    lcd_d
);

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_SETUP = 3'd1;
    localparam logic [2:0] PH_HIGH  = 3'd2;
    localparam logic [2:0] PH_HOLD  = 3'd3;
    localparam logic [2:0] PH_POST  = 3'd4;

    localparam logic [DW-1:0] EP_LAST = DW'(E_PULSE_CLKS - 1);

    logic [2:0]    phase;
    logic [DW-1:0] cnt;
    logic [DW-1:0] post_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase  <= PH_IDLE;
            cnt    <= '0;
            post_r <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            lcd_rs <= 1'b0;
            lcd_e  <= 1'b0;
            lcd_d  <= 4'h0;
        end else begin
            done <= 1'b0;
            case (phase)
                PH_IDLE: begin
                    // rs/d are latched here and stay put until the next start
                    if (start) begin
                        lcd_rs <= rs;
                        lcd_d  <= nib;
                        post_r <= post_clks;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        phase  <= PH_SETUP;
                    end
                end
                PH_SETUP: begin
                    if (cnt == EP_LAST) begin
                        cnt   <= '0;
                        lcd_e <= 1'b1;
                        phase <= PH_HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PH_HIGH: begin
                    if (cnt == EP_LAST) begin
                        cnt   <= '0;
                        lcd_e <= 1'b0;
                        phase <= PH_HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PH_HOLD: begin
                    if (cnt == EP_LAST) begin
                        cnt   <= '0;
                        phase <= PH_POST;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PH_POST: begin
                    if (cnt == post_r - 1'b1) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        phase <= PH_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_frame_driver.sv
// 32-byte frame buffer mirrored to a 16x2 HD44780 LCD over the 4-bit bus after power-up init.
// Writes land the next edge and never stall; the LCD side is paced purely by fixed delays.
module lcd_frame_driver
    import lcd_pkg::*;
#(
    parameter int CLKS_PER_US  = 50,
    parameter int E_PULSE_CLKS = 25,
    parameter int REFRESH_US   = 10000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] wr_dat,
    input  logic [4:0] wr_addr,
    input  logic       wr_en,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [3:0] lcd_d,
    output logic       init_done,
    output logic       frame_done
);

    localparam int MAX_US = (PWRUP_US > REFRESH_US) ? PWRUP_US : REFRESH_US;
    localparam int DW     = $clog2(MAX_US * CLKS_PER_US + 1);

    localparam logic [DW-1:0] D_PWRUP_LAST = DW'(PWRUP_US * CLKS_PER_US - 1);
    localparam logic [DW-1:0] D_GAP_LAST   = DW'(REFRESH_US * CLKS_PER_US - 1);
    localparam logic [DW-1:0] D_INIT3A     = DW'(INIT3A_US * CLKS_PER_US);
    localparam logic [DW-1:0] D_INIT       = DW'(INIT_US * CLKS_PER_US);
    localparam logic [DW-1:0] D_NIB_HI     = DW'(NIB_HI_US * CLKS_PER_US);
    localparam logic [DW-1:0] D_CMD        = DW'(CMD_US * CLKS_PER_US);
    localparam logic [DW-1:0] D_CLR        = DW'(CLR_US * CLKS_PER_US);

    logic [7:0]    fbuf [0:31];
    logic [3:0]    state;
    logic [4:0]    idx;
    logic          half;
    logic          inflight;
    logic [7:0]    cur_byte;
    logic [DW-1:0] wcnt;

    logic          nib_state;
    logic          byte_state;
    logic [7:0]    next_byte;
    logic [3:0]    init_nib;
    logic [DW-1:0] init_post;
    logic          tx_start;
    logic          tx_rs;
    logic [3:0]    tx_nib;
    logic [DW-1:0] tx_post;
    logic          tx_busy;
    logic          tx_done;

    assign lcd_rw = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) fbuf[i] <= 8'h20;
        end else if (wr_en) begin
            fbuf[wr_addr] <= wr_dat;
        end
    end

    always_comb begin
        nib_state  = 1'b0;
        byte_state = 1'b0;
        init_nib   = 4'h3;
        init_post  = D_INIT;
        next_byte  = 8'h00;
        tx_rs      = 1'b0;
        case (state)
            ST_INIT3A: begin
                nib_state = 1'b1;
                init_post = D_INIT3A;
            end
            ST_INIT3B, ST_INIT3C: nib_state = 1'b1;
            ST_INIT2: begin
                nib_state = 1'b1;
                init_nib  = 4'h2;
            end
            ST_CFG: begin
                byte_state = 1'b1;
                next_byte  = cfg_cmd(idx[1:0]);
            end
            ST_ADDR1: begin
                byte_state = 1'b1;
                next_byte  = DDRAM_L1;
            end
            ST_ADDR2: begin
                byte_state = 1'b1;
                next_byte  = DDRAM_L2;
            end
            ST_LINE1, ST_LINE2: begin
                byte_state = 1'b1;
                next_byte  = fbuf[idx];
                tx_rs      = 1'b1;
            end
            default: ;
        endcase

        tx_start = (nib_state || byte_state) && !tx_busy && !inflight;
        if (nib_state) begin
            tx_nib  = init_nib;
            tx_post = init_post;
        end else if (!half) begin
            tx_nib  = next_byte[7:4];
            tx_post = D_NIB_HI;
        end else begin
            tx_nib  = cur_byte[3:0];
            tx_post = (!tx_rs && (cur_byte == CLEAR || cur_byte == RET_HOME)) ? D_CLR : D_CMD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_PWRUP;
            idx        <= '0;
            half       <= 1'b0;
            inflight   <= 1'b0;
            cur_byte   <= 8'h00;
            wcnt       <= '0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // buffer byte is captured at the high-nibble start; later writes wait a frame
            if (tx_start) begin
                inflight <= 1'b1;
                if (byte_state && !half) cur_byte <= next_byte;
            end
            case (state)
                ST_PWRUP: begin
                    if (wcnt == D_PWRUP_LAST) begin
                        wcnt  <= '0;
                        state <= ST_INIT3A;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (wcnt == D_GAP_LAST) begin
                        wcnt  <= '0;
                        state <= ST_ADDR1;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: begin
                    if (tx_done) begin
                        inflight <= 1'b0;
                        if (byte_state && !half) begin
                            half <= 1'b1;
                        end else begin
                            half <= 1'b0;
                            case (state)
                                ST_INIT3A: state <= ST_INIT3B;
                                ST_INIT3B: state <= ST_INIT3C;
                                ST_INIT3C: state <= ST_INIT2;
                                ST_INIT2: begin
                                    idx   <= '0;
                                    state <= ST_CFG;
                                end
                                ST_CFG: begin
                                    if (idx == 5'd3) begin
                                        init_done <= 1'b1;
                                        state     <= ST_ADDR1;
                                    end else begin
                                        idx <= idx + 1'b1;
                                    end
                                end
                                ST_ADDR1: begin
                                    idx   <= '0;
                                    state <= ST_LINE1;
                                end
                                ST_LINE1: begin
                                    idx <= idx + 1'b1;
                                    if (idx == 5'd15) state <= ST_ADDR2;
                                end
                                ST_ADDR2: state <= ST_LINE2;
                                ST_LINE2: begin
                                    if (idx == 5'd31) begin
                                        frame_done <= 1'b1;
                                        state      <= ST_GAP;
                                    end else begin
                                        idx <= idx + 1'b1;
                                    end
                                end
                                default: state <= ST_PWRUP;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    lcd_nibble_tx #(
        .E_PULSE_CLKS (E_PULSE_CLKS),
        .DW           (DW)
    ) u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (tx_start),
        .rs        (tx_rs),
        .nib       (tx_nib),
        .post_clks (tx_post),
        .busy      (tx_busy),
        .done      (tx_done),
        .lcd_rs    (lcd_rs),
        .lcd_e     (lcd_e),
        .lcd_d     (lcd_d)
    );

endmodule

// File: tb/tb_lcd_frame_driver.sv
// Bench for lcd_frame_driver: decodes the LCD bus on each E fall and scores transfers against a queue.
module tb_lcd_frame_driver;
    import lcd_pkg::*;

    // CLKS_PER_US is 1 here so two full init sequences fit a short run
    localparam int CPU     = 1;
    localparam int EPC     = 2;
    localparam int REF_US  = 50;
    localparam int PW_CLKS = PWRUP_US * CPU;
    localparam int CLR_GAP = CLR_US * CPU;
    localparam int LIMIT   = 40000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wr_dat;
    logic [4:0] wr_addr;
    logic       wr_en;
    logic       lcd_rs, lcd_rw, lcd_e;
    logic [3:0] lcd_d;
    logic       init_done, frame_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0] exp_q[$];
    logic [7:0] mbuf[32];

    always #5 clk = ~clk;

    lcd_frame_driver #(
        .CLKS_PER_US  (CPU),
        .E_PULSE_CLKS (EPC),
        .REFRESH_US   (REF_US)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_dat     (wr_dat),
        .wr_addr    (wr_addr),
        .wr_en      (wr_en),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_e      (lcd_e),
        .lcd_d      (lcd_d),
        .init_done  (init_done),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // item = {is_single_nibble, rs, byte}
    task automatic push_init();
        exp_q.push_back({2'b10, 8'h03});
        exp_q.push_back({2'b10, 8'h03});
        exp_q.push_back({2'b10, 8'h03});
        exp_q.push_back({2'b10, 8'h02});
        exp_q.push_back({2'b00, 8'h28});
        exp_q.push_back({2'b00, 8'h0C});
        exp_q.push_back({2'b00, 8'h01});
        exp_q.push_back({2'b00, 8'h06});
    endtask

    task automatic push_frame();
        exp_q.push_back({2'b00, 8'h80});
        for (int i = 0; i < 16; i++) exp_q.push_back({2'b01, mbuf[i]});
        exp_q.push_back({2'b00, 8'hC0});
        for (int i = 16; i < 32; i++) exp_q.push_back({2'b01, mbuf[i]});
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        wr_addr = a;
        wr_dat  = d;
        wr_en   = 1'b1;
        @(posedge clk); #1;
        wr_en   = 1'b0;
        mbuf[a] = d;
    endtask

    task automatic wait_frame();
        int n = 0;
        while (!frame_done && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        check("frame_done_timeout", 32'(n < LIMIT), 32'd1);
        @(posedge clk); #1;
    endtask

    // bus monitor, sampled on the falling clock edge
    logic       prev_e, prev_fd, prev_id, have_hi, clr_pending, got_item;
    logic [3:0] hi_nib, d_r;
    logic       rs_r;
    logic [9:0] item, last_item;
    int         nib_cnt, ehigh, since_fall, fd_len;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_e = 1'b0; prev_fd = 1'b0; prev_id = 1'b0;
                have_hi = 1'b0; clr_pending = 1'b0;
                nib_cnt = 0; ehigh = 0; since_fall = 0; fd_len = 0;
                last_item = '0;
                exp_q.delete();
            end else begin
                if (lcd_e && !prev_e) begin
                    rs_r = lcd_rs;
                    d_r  = lcd_d;
                    if (clr_pending) begin
                        check("clear_gap", 32'(since_fall >= CLR_GAP), 32'd1);
                        clr_pending = 1'b0;
                    end
                end
                if (lcd_e) begin
                    ehigh++;
                    check("rs_d_stable", {27'd0, lcd_rs, lcd_d}, {27'd0, rs_r, d_r});
                end
                if (!lcd_e && prev_e) begin
                    check("e_width", ehigh, EPC);
                    ehigh = 0;
                    since_fall = 0;
                    got_item = 1'b0;
                    if (nib_cnt < 4) begin
                        item = {1'b1, lcd_rs, 4'h0, lcd_d};
                        nib_cnt++;
                        got_item = 1'b1;
                    end else if (!have_hi) begin
                        hi_nib  = lcd_d;
                        have_hi = 1'b1;
                    end else begin
                        item    = {1'b0, lcd_rs, hi_nib, lcd_d};
                        have_hi = 1'b0;
                        got_item = 1'b1;
                        if ({hi_nib, lcd_d} == 8'h01 && !lcd_rs) clr_pending = 1'b1;
                    end
                    if (got_item) begin
                        last_item = item;
                        if (exp_q.size() == 0) check("sb_extra", item, 32'h3FF);
                        else check("lcd_xfer", item, exp_q.pop_front());
                    end
                end else begin
                    since_fall++;
                end
                if (init_done && !prev_id) check("init_done_after_06", last_item, {2'b00, 8'h06});
                if (frame_done) begin
                    fd_len++;
                    if (!prev_fd) check("frame_q_drained", exp_q.size(), 0);
                end else if (prev_fd) begin
                    check("frame_done_width", fd_len, 1);
                    fd_len = 0;
                end
                prev_e  = lcd_e;
                prev_fd = frame_done;
                prev_id = init_done;
            end
        end
    end

    initial begin
        int  n;
        logic seen;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_dat = '0;
        for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rs", lcd_rs, 0);
        check("rst_rw", lcd_rw, 0);
        check("rst_e", lcd_e, 0);
        check("rst_d", lcd_d, 0);
        check("rst_init_done", init_done, 0);
        check("rst_frame_done", frame_done, 0);

        push_init();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (PW_CLKS) begin
            @(posedge clk); #1;
            if (lcd_e) seen = 1'b1;
        end
        check("pwrup_quiet", seen, 0);

        wr(5'd0, 8'h58);
        wr(5'd1, 8'h3A);
        wr(5'd15, 8'h37);
        wr(5'd16, 8'h59);
        wr(5'd31, 8'h39);
        push_frame();
        wait_frame();
        check("init_done_held", init_done, 1);

        // write buf[5] on the very edge that fetches it
        push_frame();
        n = 0;
        while (!(dut.tx_start && dut.state == ST_LINE1 && dut.idx == 5'd5 && !dut.half) && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        check("fetch5_timeout", 32'(n < LIMIT), 32'd1);
        wr(5'd5, 8'h41);
        wait_frame();

        push_frame();
        n = 0;
        while (!(dut.state == ST_LINE2 && lcd_e) && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        check("line2_e_timeout", 32'(n < LIMIT), 32'd1);
        check("e_high_before_rst", lcd_e, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_e", lcd_e, 0);
        check("midrst_init_done", init_done, 0);
        check("midrst_frame_done", frame_done, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
        push_init();
        push_frame();
        wait_frame();
        check("reinit_init_done", init_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
